vram_slot_arbiter: RTL
======================

// Module: vram_slot_arbiter
// PURPOSE
//  Parametrised N-channel VRAM slot arbiter; successor to the fixed CPU/command/sprite/draw access switch.
//  - Once per access slot (DOTSTATE==2'b10) it picks one VRAM master: display, sprite, or one of NUM_CH toggle-handshake channels.
//  - It drives the registered VRAM address/data/strobe bus.
//  - Channels carry CPU port, command engine, super-res blitter, etc.
// PARAMETERS
//  NUM_CH       4   number of toggle-handshake requester channels (1..8)
//  ADDR_W      17   VRAM address width
//  DATA_W      32   write data width
//  STARVE_LIMIT 8   slots a pending channel may lose before preempting the sprite slot (1..255)
// PORTS
//  CLK21M       in   1               system clock
//  RESET_N      in   1               synchronous reset, active low
//  DOTSTATE     in   2               dot phase; 2'b10 = arbitration slot
//  DISP_SLOT    in   1               display owns this slot (already gated by DISP_ON/window)
//  DISP_ADDR    in   ADDR_W          display fetch address
//  DISP_SIZE    in   2               display fetch width (`MEMORY_WIDTH_*)
//  SPR_SLOT     in   1               sprite engine requests this slot
//  SPR_ADDR     in   ADDR_W          sprite fetch address
//  CH_REQ       in   NUM_CH          per-channel request toggle
//  CH_WE        in   NUM_CH          1 = write, 0 = read
//  CH_ADDR      in   NUM_CH*ADDR_W   packed addresses; channel i = [i*ADDR_W +: ADDR_W]
//  CH_WDATA     in   NUM_CH*DATA_W   packed write data
//  CH_SIZE      in   NUM_CH*2        packed access width
//  CH_ACK       out  NUM_CH          per-channel acknowledge toggle
//  CH_READING   out  NUM_CH          toggles when a read is issued for channel i
//  IRAMADR      out  ADDR_W          VRAM address
//  PRAMDBO_32   out  DATA_W          VRAM write data
//  PRAMWE_N     out  1               write strobe, active low
//  PRAM_SIZE    out  2               access width
//  GRANT_SRC    out  2               0 idle, 1 display, 2 sprite, 3 channel
//  GRANT_CH     out  $clog2(NUM_CH)  granted channel index; valid when GRANT_SRC==3
// BEHAVIOUR
//  - Reset (RESET_N low at posedge) values:
//    - IRAMADR all ones; PRAMDBO_32 0; PRAMWE_N 1; PRAM_SIZE `MEMORY_WIDTH_16.
//    - CH_ACK, CH_READING, GRANT_SRC, GRANT_CH, wait counters and RR pointer all 0.
//  - Reset mid-access abandons any pending request. Requesters must reset their CH_REQ alongside.
//  - Channel i is pending while CH_REQ[i] != CH_ACK[i]. A second toggle while pending is a protocol error; the arbiter does not detect it.
//  - Non-slot cycles (DOTSTATE != 2'b10): PRAMWE_N<=1, GRANT_SRC<=0; all other outputs hold.
//  - Slot priority:
//    1. DISP_SLOT
//    2. starved channel (wait counter == STARVE_LIMIT)
//    3. SPR_SLOT
//    4. any other pending channel
//    5. idle
//  - Display grant: IRAMADR<=DISP_ADDR, PRAM_SIZE<=DISP_SIZE, PRAMWE_N<=1.
//  - Sprite grant: IRAMADR<=SPR_ADDR, PRAM_SIZE<=`MEMORY_WIDTH_16, PRAMWE_N<=1.
//  - Channel grant i, one per slot:
//    - IRAMADR<=addr_i, PRAM_SIZE<=size_i, PRAMWE_N<=~CH_WE[i].
//    - PRAMDBO_32<=wdata_i on a write; held on a read.
//    - CH_ACK[i] toggles in the same edge. On a read, CH_READING[i] also toggles.
//  - Latency: request seen at slot edge -> bus and ACK valid the next cycle. Minimum one slot (4 clocks).
//  - Write strobe is exactly one cycle wide.
//  - Idle slot: IRAMADR holds, PRAMWE_N<=1.
//  - Choosing among several pending channels (after starvation check):
//    - Fixed priority: lowest index wins.
//    - Several starved channels: lowest index wins.
//  - Wait counters, per channel, saturating at STARVE_LIMIT:
//    - +1 each slot the channel is pending but not granted.
//    - Cleared on grant or when the channel is not pending.
//  - Display never yields; starvation only preempts the sprite slot.
//  - Simultaneous request toggle and grant on the same edge: the grant uses the sampled (pre-edge) CH_REQ.
// CONFIGURATION
//  VRAM_ARB_ROUND_ROBIN_EN
//  - Defined: non-starved channel selection is round-robin. The search starts at (last granted channel + 1) mod NUM_CH; the pointer updates only on channel grants.
//  - Undefined: fixed lowest-index priority, and no pointer register is built.
// TESTING
//  1. Reset, then CH_REQ[1] toggles 0->1 with WE=1, ADDR=17'h00123, WDATA=32'hA5, idle slot:
//     next cycle IRAMADR=17'h00123, PRAMWE_N=0, PRAMDBO_32=32'hA5, CH_ACK[1]=1, GRANT_SRC=3, GRANT_CH=1; following cycle PRAMWE_N=1.
//  2. DISP_SLOT=1 and SPR_SLOT=1 with channel 0 pending (read) at a slot:
//     GRANT_SRC=1, IRAMADR=DISP_ADDR, CH_ACK[0] unchanged, CH_READING[0] unchanged.
//  3. SPR_SLOT held 1 and channel 2 pending, STARVE_LIMIT=8:
//     sprite granted 8 slots; 9th slot GRANT_CH=2, CH_ACK[2] toggles, counter resets to 0.
//  4. Channels 0 and 3 pending at the same slot:
//     fixed priority grants ch0 then ch3 on consecutive slots. With VRAM_ARB_ROUND_ROBIN_EN after a ch0 grant, both re-pending -> ch3 first.
//  5. RESET_N low for one cycle while channel 1 is mid-grant (PRAMWE_N=0):
//     next cycle PRAMWE_N=1, IRAMADR=17'h1FFFF, CH_ACK=0, GRANT_SRC=0.
//  6. Toggle CH_REQ[0] on a non-slot cycle (DOTSTATE=2'b01):
//     no grant until the next DOTSTATE=2'b10 edge; no bus change in between.

Source files
------------

// File: rtl/vram_slot_arbiter_if.sv
// VRAM slot arbiter bundle: slot requests, toggle-handshake channels and the registered VRAM bus.
// master = requester/bus-consumer side, slave = arbiter side.
interface vram_slot_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [1:0]               DOTSTATE;
  logic                     DISP_SLOT;
  logic [ADDR_W-1:0]        DISP_ADDR;
  logic [1:0]               DISP_SIZE;
  logic                     SPR_SLOT;
  logic [ADDR_W-1:0]        SPR_ADDR;
  logic [NUM_CH-1:0]        CH_REQ;
  logic [NUM_CH-1:0]        CH_WE;
  logic [NUM_CH*ADDR_W-1:0] CH_ADDR;
  logic [NUM_CH*DATA_W-1:0] CH_WDATA;
  logic [NUM_CH*2-1:0]      CH_SIZE;
  logic [NUM_CH-1:0]        CH_ACK;
  logic [NUM_CH-1:0]        CH_READING;
  logic [ADDR_W-1:0]        IRAMADR;
  logic [DATA_W-1:0]        PRAMDBO_32;
  logic                     PRAMWE_N;
  logic [1:0]               PRAM_SIZE;
  logic [1:0]               GRANT_SRC;
  logic [CH_W-1:0]          GRANT_CH;

  modport master (
    output DOTSTATE, DISP_SLOT, DISP_ADDR, DISP_SIZE, SPR_SLOT, SPR_ADDR,
           CH_REQ, CH_WE, CH_ADDR, CH_WDATA, CH_SIZE,
    input  CH_ACK, CH_READING, IRAMADR, PRAMDBO_32, PRAMWE_N, PRAM_SIZE,
           GRANT_SRC, GRANT_CH
  );

  modport slave (
    input  DOTSTATE, DISP_SLOT, DISP_ADDR, DISP_SIZE, SPR_SLOT, SPR_ADDR,
           CH_REQ, CH_WE, CH_ADDR, CH_WDATA, CH_SIZE,
    output CH_ACK, CH_READING, IRAMADR, PRAMDBO_32, PRAMWE_N, PRAM_SIZE,
           GRANT_SRC, GRANT_CH
  );
endinterface

// File: rtl/vram_slot_arbiter.sv
// N-channel VRAM slot arbiter: display > starved channel > sprite > pending channel, one grant per slot.
// Optional VRAM_ARB_ROUND_ROBIN_EN: round-robin choice among non-starved channels.
`ifndef MEMORY_WIDTH_8
`define MEMORY_WIDTH_8 2'b00
`endif
`ifndef MEMORY_WIDTH_16
`define MEMORY_WIDTH_16 2'b01
`endif
`ifndef MEMORY_WIDTH_32
`define MEMORY_WIDTH_32 2'b10
`endif

module vram_slot_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input logic                CLK21M,
  input logic                RESET_N,
  vram_slot_arbiter_if.slave bus
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_DISP = 2'd1,
    SRC_SPR  = 2'd2,
    SRC_CH   = 2'd3
  } src_e;

  logic [ADDR_W-1:0]             iramadr_p1;
  logic [DATA_W-1:0]             pramdbo_p1;
  logic                          pramwe_n_p1;
  logic [1:0]                    pram_size_p1;
  logic [NUM_CH-1:0]             ch_ack_p1;
  logic [NUM_CH-1:0]             ch_reading_p1;
  src_e                          grant_src_p1;
  logic [CH_W-1:0]               grant_ch_p1;
  logic [NUM_CH-1:0][CNT_W-1:0]  wait_cnt_p1;

  logic [ADDR_W-1:0]             ch_addr  [NUM_CH];
  logic [DATA_W-1:0]             ch_wdata [NUM_CH];
  logic [1:0]                    ch_size  [NUM_CH];
  logic [NUM_CH-1:0]             pending;
  logic [NUM_CH-1:0]             starved;
  src_e                          sel_src;
  logic [CH_W-1:0]               sel_ch;
  logic [NUM_CH-1:0][CNT_W-1:0]  wait_cnt_nxt;
  logic                          slot;

  function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = CH_W'(i);
    end
  endfunction

`ifdef VRAM_ARB_ROUND_ROBIN_EN
  logic [CH_W-1:0] rr_ptr_p1;

  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] v,
                                              input logic [CH_W-1:0]   last);
    logic            found;
    int              t;
    logic [CH_W-1:0] ci;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      t  = (int'(last) + k) % NUM_CH;
      ci = CH_W'(t);
      if (!found && v[ci]) begin
        rr_pick = ci;
        found   = 1'b1;
      end
    end
  endfunction
`endif

  assign slot = (bus.DOTSTATE == 2'b10);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_addr[i]  = bus.CH_ADDR[i*ADDR_W +: ADDR_W];
      ch_wdata[i] = bus.CH_WDATA[i*DATA_W +: DATA_W];
      ch_size[i]  = bus.CH_SIZE[i*2 +: 2];
    end
  end

  // Slot decision from the pre-edge CH_REQ and the registered ACK state
  always_comb begin
    pending = bus.CH_REQ ^ ch_ack_p1;
    for (int i = 0; i < NUM_CH; i++) begin
      starved[i] = pending[i] && (wait_cnt_p1[i] == CNT_MAX);
    end
    sel_src = SRC_IDLE;
    sel_ch  = '0;
    if (bus.DISP_SLOT) begin
      sel_src = SRC_DISP;
    end else if (|starved) begin
      sel_src = SRC_CH;
      sel_ch  = lowest_idx(starved);
    end else if (bus.SPR_SLOT) begin
      sel_src = SRC_SPR;
    end else if (|pending) begin
      sel_src = SRC_CH;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
      sel_ch  = rr_pick(pending, rr_ptr_p1);
`else
      sel_ch  = lowest_idx(pending);
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wait_cnt_nxt[i] = wait_cnt_p1[i];
      if (!pending[i] || (sel_src == SRC_CH && sel_ch == CH_W'(i))) begin
        wait_cnt_nxt[i] = '0;
      end else if (wait_cnt_p1[i] < CNT_MAX) begin
        wait_cnt_nxt[i] = wait_cnt_p1[i] + 1'b1;
      end
    end
  end

  // Registered VRAM bus stage
  always_ff @(posedge CLK21M) begin
    if (!RESET_N) begin
      iramadr_p1    <= '1;
      pramdbo_p1    <= '0;
      pramwe_n_p1   <= 1'b1;
      pram_size_p1  <= `MEMORY_WIDTH_16;
      ch_ack_p1     <= '0;
      ch_reading_p1 <= '0;
      grant_src_p1  <= SRC_IDLE;
      grant_ch_p1   <= '0;
      wait_cnt_p1   <= '0;
    end else if (!slot) begin
      pramwe_n_p1  <= 1'b1;
      grant_src_p1 <= SRC_IDLE;
    end else begin
      pramwe_n_p1  <= 1'b1;
      grant_src_p1 <= sel_src;
      wait_cnt_p1  <= wait_cnt_nxt;
      case (sel_src)
        SRC_DISP: begin
          iramadr_p1   <= bus.DISP_ADDR;
          pram_size_p1 <= bus.DISP_SIZE;
        end
        SRC_SPR: begin
          iramadr_p1   <= bus.SPR_ADDR;
          pram_size_p1 <= `MEMORY_WIDTH_16;
        end
        SRC_CH: begin
          iramadr_p1           <= ch_addr[sel_ch];
          pram_size_p1         <= ch_size[sel_ch];
          pramwe_n_p1          <= ~bus.CH_WE[sel_ch];
          grant_ch_p1          <= sel_ch;
          ch_ack_p1[sel_ch]    <= ~ch_ack_p1[sel_ch];
          if (bus.CH_WE[sel_ch]) begin
            pramdbo_p1 <= ch_wdata[sel_ch];
          end else begin
            ch_reading_p1[sel_ch] <= ~ch_reading_p1[sel_ch];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VRAM_ARB_ROUND_ROBIN_EN
  // Pointer remembers the last granted channel; only channel grants move it
  always_ff @(posedge CLK21M) begin
    if (!RESET_N) begin
      rr_ptr_p1 <= '0;
    end else if (slot && sel_src == SRC_CH) begin
      rr_ptr_p1 <= sel_ch;
    end
  end
`endif

  assign bus.IRAMADR    = iramadr_p1;
  assign bus.PRAMDBO_32 = pramdbo_p1;
  assign bus.PRAMWE_N   = pramwe_n_p1;
  assign bus.PRAM_SIZE  = pram_size_p1;
  assign bus.CH_ACK     = ch_ack_p1;
  assign bus.CH_READING = ch_reading_p1;
  assign bus.GRANT_SRC  = grant_src_p1;
  assign bus.GRANT_CH   = grant_ch_p1;

endmodule
